// File: rtl/xor_frame_accumulator_if.sv
// Stream bundle for xor_frame_accumulator.
//   in_valid/in_ready/in_data/in_last : word input stream
//   out_valid/out_ready               : frame result handshake
//   out_word/out_parity/out_count     : frame result payload
// slave  : the accumulator side
// master : the producer/consumer side (testbench or surrounding logic)
interface xor_frame_accumulator_if #(
   parameter int WIDTH = 8,
   parameter int CW    = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_word;
   logic             out_parity;
   logic [CW-1:0]    out_count;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_word, out_parity, out_count
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_word, out_parity, out_count
   );
endinterface

// File: rtl/xor_frame_accumulator.sv
// XOR frame accumulator: folds up to FRAME_LEN words (or fewer, closed by
// in_last) into one XOR word plus its parity, and presents one result per
// frame on a valid/ready handshake.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : stream bundle (slave modport), see xor_frame_accumulator_if
//   frame_cnt : frames emitted since reset, wraps modulo 2^CNT_W
//
// state | meaning
// ------+---------------------------------------------
// ACC   | collecting words, in_ready = 1
// HOLD  | result presented, waiting for out_ready
module xor_frame_accumulator #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   parameter int CNT_W     = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   xor_frame_accumulator_if.slave     bus,
   output logic [CNT_W-1:0]           frame_cnt
);
   localparam int CW = $clog2(FRAME_LEN + 1);

   typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_word_q, out_word_d;
   logic             out_parity_q, out_parity_d;
   logic [CW-1:0]    out_count_q, out_count_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic [CW-1:0]    cnt_inc;
   logic [WIDTH-1:0] acc_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_ACC;
         acc_q        <= '0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_word_q   <= '0;
         out_parity_q <= 1'b0;
         out_count_q  <= '0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_word_q   <= out_word_d;
         out_parity_q <= out_parity_d;
         out_count_q  <= out_count_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      out_word_d   = out_word_q;
      out_parity_d = out_parity_q;
      out_count_d  = out_count_q;
      frame_cnt_d  = frame_cnt_q;
      cnt_inc      = cnt_q + CW'(1);
      acc_nxt      = acc_q ^ bus.in_data;

      case (state_q)
         ST_ACC: begin
            // in_ready is 1 here, so in_valid alone marks a transfer
            if (bus.in_valid) begin
               if (cnt_inc == CW'(FRAME_LEN) || bus.in_last) begin
                  out_word_d   = acc_nxt;
                  out_parity_d = ^acc_nxt;
                  out_count_d  = cnt_inc;
                  out_valid_d  = 1'b1;
                  state_d      = ST_HOLD;
                  acc_d        = '0;
                  cnt_d        = '0;
               end else begin
                  acc_d = acc_nxt;
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               state_d     = ST_ACC;
            end
         end
      endcase
   end

   assign bus.in_ready   = (state_q == ST_ACC);
   assign bus.out_valid  = out_valid_q;
   assign bus.out_word   = out_word_q;
   assign bus.out_parity = out_parity_q;
   assign bus.out_count  = out_count_q;
   assign frame_cnt      = frame_cnt_q;
endmodule

// File: tb/tb_xor_frame_accumulator.sv
// Testbench for xor_frame_accumulator: directed frames against a queue-based
// frame model, plus literal expectations and a CNT_W=4 wrap instance.
module tb_xor_frame_accumulator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   xor_frame_accumulator_if #(.WIDTH(8), .CW(3)) ifc ();
   xor_frame_accumulator_if #(.WIDTH(8), .CW(3)) ifc2 ();
   logic [15:0] frame_cnt;
   logic [3:0]  frame_cnt2;

   xor_frame_accumulator #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc.slave), .frame_cnt(frame_cnt));

   xor_frame_accumulator #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(ifc2.slave), .frame_cnt(frame_cnt2));

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame model: words of the open frame in a queue; a closed frame is
   // reduced with plain XOR and held until the consumer takes it.
   logic [7:0] m_words[$];
   bit         m_hold = 1'b0;
   logic [7:0] m_word = '0;
   bit         m_par = 1'b0;
   int         m_count = 0;
   int         m_frames = 0;

   always @(posedge clk) begin
      chk_en <= 1'b1;
      if (!rst_n) begin
         m_words.delete();
         m_hold = 1'b0; m_word = '0; m_par = 1'b0; m_count = 0; m_frames = 0;
      end else if (m_hold) begin
         if (ifc.out_ready) begin
            m_hold = 1'b0;
            m_frames = (m_frames + 1) % 65536;
         end
      end else if (ifc.in_valid) begin
         m_words.push_back(ifc.in_data);
         if (m_words.size() == 4 || ifc.in_last) begin
            m_word = '0;
            foreach (m_words[i]) m_word = m_word ^ m_words[i];
            m_par = 1'b0;
            for (int b = 0; b < 8; b++) m_par = m_par ^ m_word[b];
            m_count = m_words.size();
            m_words.delete();
            m_hold = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", 32'(ifc.in_ready), 32'(!m_hold));
         check("out_valid", 32'(ifc.out_valid), 32'(m_hold));
         check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
         if (m_hold) begin
            check("out_word", 32'(ifc.out_word), 32'(m_word));
            check("out_parity", 32'(ifc.out_parity), 32'(m_par));
            check("out_count", 32'(ifc.out_count), 32'(m_count));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the word is accepted.
   task automatic send(input logic [7:0] d, input logic l);
      int t = 0;
      while (!ifc.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!ifc.in_ready) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
      end
      ifc.in_valid = 1'b1; ifc.in_data = d; ifc.in_last = l;
      @(negedge clk);
      ifc.in_valid = 1'b0; ifc.in_last = 1'b0;
   endtask

   task automatic expect_frame(input string name, input logic [7:0] w, input logic p, input int c);
      check({name, "_valid"}, 32'(ifc.out_valid), 32'd1);
      check({name, "_word"}, 32'(ifc.out_word), 32'(w));
      check({name, "_parity"}, 32'(ifc.out_parity), 32'(p));
      check({name, "_count"}, 32'(ifc.out_count), 32'(c));
   endtask

   initial begin
      ifc.in_valid = 0; ifc.in_data = 0; ifc.in_last = 0; ifc.out_ready = 0;
      ifc2.in_valid = 0; ifc2.in_data = 0; ifc2.in_last = 0; ifc2.out_ready = 0;

      // 1: reset with random inputs
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         ifc.in_valid = 1'($urandom); ifc.in_data = 8'($urandom);
         ifc.in_last = 1'($urandom); ifc.out_ready = 1'($urandom);
      end
      @(negedge clk);
      ifc.in_valid = 0; ifc.in_last = 0; ifc.out_ready = 0;
      rst_n = 1'b1;
      check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      check("rst_out_word", 32'(ifc.out_word), 32'd0);
      check("rst_out_parity", 32'(ifc.out_parity), 32'd0);
      check("rst_out_count", 32'(ifc.out_count), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

      // 2: full frame
      ifc.out_ready = 1'b1;
      send(8'h01, 0); send(8'h02, 0); send(8'h04, 0); send(8'h08, 0);
      expect_frame("full", 8'h0F, 1'b0, 4);
      @(negedge clk);
      check("full_frame_cnt", 32'(frame_cnt), 32'd1);
      check("full_in_ready", 32'(ifc.in_ready), 32'd1);

      // 3: short frames
      send(8'hFF, 0); send(8'h01, 1);
      expect_frame("short2", 8'hFE, 1'b1, 2);
      send(8'h03, 1);
      expect_frame("short1", 8'h03, 1'b0, 1);

      // 4: backpressure
      @(negedge clk);
      ifc.out_ready = 1'b0;
      send(8'hAA, 0); send(8'h55, 0); send(8'h00, 0); send(8'h0F, 0);
      ifc.in_valid = 1'b1; ifc.in_data = 8'h77;
      repeat (5) begin
         check("bp_word", 32'(ifc.out_word), 32'hF0);
         check("bp_valid", 32'(ifc.out_valid), 32'd1);
         check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
         @(negedge clk);
      end
      ifc.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", 32'(ifc.out_valid), 32'd0);
      check("bp_release_in_ready", 32'(ifc.in_ready), 32'd1);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
      expect_frame("bp_next", 8'h77, 1'b0, 4);

      // 5: gapped input
      @(negedge clk);
      send(8'h10, 0);
      repeat (3) @(negedge clk);
      send(8'h20, 0);
      repeat (3) @(negedge clk);
      send(8'h40, 1);
      expect_frame("gap", 8'h70, 1'b1, 3);

      // 6: reset mid-frame discards the partial frame
      @(negedge clk);
      send(8'h11, 0); send(8'h22, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_valid", 32'(ifc.out_valid), 32'd0);
      check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
      send(8'h01, 0); send(8'h01, 0); send(8'h01, 0); send(8'h01, 0);
      expect_frame("midrst_next", 8'h00, 1'b0, 4);
      @(negedge clk);
      check("midrst_next_frame_cnt", 32'(frame_cnt), 32'd1);

      // 6b: CNT_W=4 wraps after 17 single-word frames (2 cycles each)
      ifc2.in_valid = 1'b1; ifc2.in_last = 1'b1; ifc2.out_ready = 1'b1; ifc2.in_data = 8'h5A;
      repeat (34) @(negedge clk);
      ifc2.in_valid = 1'b0; ifc2.in_last = 1'b0;
      check("wrap_frame_cnt", 32'(frame_cnt2), 32'd1);
      check("wrap_in_ready", 32'(ifc2.in_ready), 32'd1);
      check("wrap_out_word", 32'(ifc2.out_word), 32'h5A);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
